multi_port_stream_serializer: RTL and testbench

Downstream consumer of a multi-port stream FIFO's dequeue side. Each cycle it accepts a contiguous batch of up to `InWidth` entries from lane 0 upward and holds it in an internal buffer. It then emits the entries one per cycle, in lane order, on a single valid/ready output port. This narrows a superscalar queue into a scalar pipeline stage with no bubble between batches.

---
 rtl/multi_port_stream_serializer_pkg.sv | 28 ++
 rtl/multi_port_stream_serializer_lane_prefix_count.sv | 48 ++++
 rtl/multi_port_stream_serializer.sv | 108 ++++++++++
 tb/tb_multi_port_stream_serializer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_port_stream_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multi_port_stream_serializer_pkg
// Brief    : Shared types and width helpers for the stream serializer slice.
// Revision : 1.0 - initial release
// ============================================================================
package multi_port_stream_serializer_pkg;

    // Per-cycle register update selected by the serializer control logic.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_POP   = 2'd2,
        OP_FLUSH = 2'd3
    } op_e;

    // Width of a counter that must hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Width of an index into n slots, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_port_stream_serializer_lane_prefix_count.sv
`default_nettype none
// ============================================================================
// Module   : multi_port_stream_serializer_lane_prefix_count
// Brief    : Combinational lane-narrowing helper. Grants ready only to the
//            contiguous valid prefix starting at lane 0 and counts the lanes
//            that fire.
// Revision : 1.0 - initial release
// ============================================================================
module multi_port_stream_serializer_lane_prefix_count
    import multi_port_stream_serializer_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic [LANES-1:0]            i_vld,
    input  logic                        i_load_ok,
    output logic [LANES-1:0]            o_rdy,
    output logic [LANES-1:0]            o_fire,
    output logic [cnt_width(LANES)-1:0] o_count
);

    localparam int c_CNT_WIDTH = cnt_width(LANES);

    logic [LANES-1:0] w_prefix;

    // Lane i is eligible only when every lower lane is valid (no gaps).
    always_comb begin
        w_prefix    = '0;
        w_prefix[0] = 1'b1;
        for (int i = 1; i < LANES; i++) begin
            w_prefix[i] = w_prefix[i-1] & i_vld[i-1];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign o_rdy[g]  = i_load_ok & w_prefix[g];
        assign o_fire[g] = i_vld[g] & o_rdy[g];
    end

    // Popcount of fired lanes; equals the length of the accepted prefix.
    always_comb begin
        o_count = '0;
        for (int i = 0; i < LANES; i++) begin
            o_count = o_count + c_CNT_WIDTH'(o_fire[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/multi_port_stream_serializer.sv
`default_nettype none
// ============================================================================
// Module   : multi_port_stream_serializer
// Brief    : Accepts a batch of up to IN_WIDTH entries per cycle from a
//            multi-port FIFO dequeue side and replays them one per cycle, in
//            lane order, on a single valid/ready port with no inter-batch
//            bubble.
// Revision : 1.0 - initial release
// ============================================================================
module multi_port_stream_serializer
    import multi_port_stream_serializer_pkg::*;
#(
    parameter int IN_WIDTH   = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [IN_WIDTH-1:0]                 in_vld_i,
    input  logic [IN_WIDTH-1:0][DATA_WIDTH-1:0] in_payload_i,
    output logic [IN_WIDTH-1:0]                 in_rdy_o,
    output logic                                out_vld_o,
    output logic [DATA_WIDTH-1:0]               out_payload_o,
    input  logic                                out_rdy_i,
    input  logic                                flush_i
);

    localparam int c_CNT_WIDTH = cnt_width(IN_WIDTH);
    localparam int c_IDX_WIDTH = idx_width(IN_WIDTH);

    logic [DATA_WIDTH-1:0]  r_hold_payload [IN_WIDTH];
    logic [c_CNT_WIDTH-1:0] r_cnt;
    logic [c_IDX_WIDTH-1:0] r_rd_idx;

    logic [IN_WIDTH-1:0]    w_fire;
    logic [c_CNT_WIDTH-1:0] w_fire_cnt;
    logic                   w_out_fire;
    logic                   w_load_ok;
    op_e                    w_op;

    // Outputs come straight from state: valid from the count, data via index mux.
    assign out_vld_o     = (r_cnt != '0);
    assign out_payload_o = r_hold_payload[r_rd_idx];
    assign w_out_fire    = out_vld_o & out_rdy_i;

    // Accept a new batch when empty, or when the last held entry leaves now.
    assign w_load_ok = ~flush_i &
                       ((r_cnt == '0) | ((r_cnt == c_CNT_WIDTH'(1)) & w_out_fire));

    multi_port_stream_serializer_lane_prefix_count #(
        .LANES (IN_WIDTH)
    ) u_prefix (
        .i_vld     (in_vld_i),
        .i_load_ok (w_load_ok),
        .o_rdy     (in_rdy_o),
        .o_fire    (w_fire),
        .o_count   (w_fire_cnt)
    );

    // Pick this cycle's update; flush beats load, load beats pop.
    always_comb begin
        w_op = OP_HOLD;
        if (flush_i) begin
            w_op = OP_FLUSH;
        end else if (w_fire != '0) begin
            w_op = OP_LOAD;
        end else if (w_out_fire) begin
            w_op = OP_POP;
        end
    end

    // Count and read index; reset drops any held entries immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_rd_idx <= '0;
        end else begin
            case (w_op)
                OP_FLUSH: begin
                    r_cnt    <= '0;
                    r_rd_idx <= '0;
                end
                OP_LOAD: begin
                    r_cnt    <= w_fire_cnt;
                    r_rd_idx <= '0;
                end
                OP_POP: begin
                    r_cnt    <= r_cnt - c_CNT_WIDTH'(1);
                    r_rd_idx <= r_rd_idx + c_IDX_WIDTH'(1);
                end
                default: begin
                    r_cnt    <= r_cnt;
                    r_rd_idx <= r_rd_idx;
                end
            endcase
        end
    end

    // Payload slots capture their lane on fire; contents are don't-care when empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (w_fire[i]) begin
                r_hold_payload[i] <= in_payload_i[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_port_stream_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_port_stream_serializer
// Brief    : Directed self-checking bench for the stream serializer
//            (IN_WIDTH=2, DATA_WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multi_port_stream_serializer;

    localparam int IN_WIDTH   = 2;
    localparam int DATA_WIDTH = 32;

    logic                                clk;
    logic                                rst;
    logic [IN_WIDTH-1:0]                 in_vld_i;
    logic [IN_WIDTH-1:0][DATA_WIDTH-1:0] in_payload_i;
    logic [IN_WIDTH-1:0]                 in_rdy_o;
    logic                                out_vld_o;
    logic [DATA_WIDTH-1:0]               out_payload_o;
    logic                                out_rdy_i;
    logic                                flush_i;

    int errors = 0;
    int checks = 0;

    multi_port_stream_serializer #(
        .IN_WIDTH   (IN_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_vld_i      (in_vld_i),
        .in_payload_i  (in_payload_i),
        .in_rdy_o      (in_rdy_o),
        .out_vld_o     (out_vld_o),
        .out_payload_o (out_payload_o),
        .out_rdy_i     (out_rdy_i),
        .flush_i       (flush_i)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge; inputs change and outputs are sampled there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] vld, input logic [31:0] p0, input logic [31:0] p1);
        in_vld_i        = vld;
        in_payload_i[0] = p0;
        in_payload_i[1] = p1;
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        flush_i   = 1'b0;
        out_rdy_i = 1'b0;
        drive(2'b00, 32'h0, 32'h0);
        tick();
        checks++;
        if (out_vld_o !== 1'b0) begin
            errors++; $display("FAIL reset_out_vld: got %b expected 0", out_vld_o);
        end
        checks++;
        if (in_rdy_o !== 2'b01) begin
            errors++; $display("FAIL reset_in_rdy_00: got %b expected 01", in_rdy_o);
        end
        drive(2'b11, 32'h0, 32'h0);
        checks++;
        if (in_rdy_o !== 2'b11) begin
            errors++; $display("FAIL reset_in_rdy_11: got %b expected 11", in_rdy_o);
        end
        drive(2'b00, 32'h0, 32'h0);
        rst = 1'b0;
        tick();
        checks++;
        if (out_vld_o !== 1'b0) begin
            errors++; $display("FAIL reset_release_vld: got %b expected 0", out_vld_o);
        end
    endtask

    task automatic test_back_to_back();
        out_rdy_i = 1'b1;
        drive(2'b11, 32'hA, 32'hB);
        checks++;
        if (in_rdy_o !== 2'b11) begin
            errors++; $display("FAIL b2b_rdy_empty: got %b expected 11", in_rdy_o);
        end
        tick();
        drive(2'b11, 32'hC, 32'hD);
        checks++;
        if (out_vld_o !== 1'b1 || out_payload_o !== 32'hA) begin
            errors++; $display("FAIL b2b_out_A: got vld=%b data=%h expected vld=1 data=a", out_vld_o, out_payload_o);
        end
        checks++;
        if (in_rdy_o !== 2'b00) begin
            errors++; $display("FAIL b2b_rdy_during_A: got %b expected 00", in_rdy_o);
        end
        tick();
        checks++;
        if (out_vld_o !== 1'b1 || out_payload_o !== 32'hB) begin
            errors++; $display("FAIL b2b_out_B: got vld=%b data=%h expected vld=1 data=b", out_vld_o, out_payload_o);
        end
        checks++;
        if (in_rdy_o !== 2'b11) begin
            errors++; $display("FAIL b2b_rdy_during_B: got %b expected 11", in_rdy_o);
        end
        tick();
        drive(2'b00, 32'h0, 32'h0);
        checks++;
        if (out_vld_o !== 1'b1 || out_payload_o !== 32'hC) begin
            errors++; $display("FAIL b2b_out_C: got vld=%b data=%h expected vld=1 data=c", out_vld_o, out_payload_o);
        end
        tick();
        checks++;
        if (out_vld_o !== 1'b1 || out_payload_o !== 32'hD) begin
            errors++; $display("FAIL b2b_out_D: got vld=%b data=%h expected vld=1 data=d", out_vld_o, out_payload_o);
        end
        tick();
        checks++;
        if (out_vld_o !== 1'b0) begin
            errors++; $display("FAIL b2b_drained: got %b expected 0", out_vld_o);
        end
    endtask

    task automatic test_backpressure();
        out_rdy_i = 1'b0;
        drive(2'b11, 32'hA, 32'hB);
        tick();
        drive(2'b11, 32'h1, 32'h2);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_vld_o !== 1'b1 || out_payload_o !== 32'hA) begin
                errors++; $display("FAIL bp_hold_A[%0d]: got vld=%b data=%h expected vld=1 data=a", c, out_vld_o, out_payload_o);
            end
            checks++;
            if (in_rdy_o !== 2'b00) begin
                errors++; $display("FAIL bp_rdy[%0d]: got %b expected 00", c, in_rdy_o);
            end
            tick();
        end
        drive(2'b00, 32'h0, 32'h0);
        out_rdy_i = 1'b1;
        #1;
        checks++;
        if (out_vld_o !== 1'b1 || out_payload_o !== 32'hA) begin
            errors++; $display("FAIL bp_release_A: got vld=%b data=%h expected vld=1 data=a", out_vld_o, out_payload_o);
        end
        tick();
        checks++;
        if (out_vld_o !== 1'b1 || out_payload_o !== 32'hB) begin
            errors++; $display("FAIL bp_release_B: got vld=%b data=%h expected vld=1 data=b", out_vld_o, out_payload_o);
        end
        tick();
        checks++;
        if (out_vld_o !== 1'b0) begin
            errors++; $display("FAIL bp_drained: got %b expected 0", out_vld_o);
        end
    endtask

    task automatic test_non_prefix();
        out_rdy_i = 1'b1;
        drive(2'b10, 32'h0, 32'h99);
        checks++;
        if (in_rdy_o !== 2'b01) begin
            errors++; $display("FAIL np_rdy_10: got %b expected 01", in_rdy_o);
        end
        tick();
        checks++;
        if (out_vld_o !== 1'b0) begin
            errors++; $display("FAIL np_no_fire: got vld=%b expected 0", out_vld_o);
        end
        drive(2'b01, 32'h5, 32'h77);
        checks++;
        if (in_rdy_o !== 2'b11) begin
            errors++; $display("FAIL np_rdy_01: got %b expected 11", in_rdy_o);
        end
        tick();
        drive(2'b01, 32'h6, 32'h0);
        checks++;
        if (out_vld_o !== 1'b1 || out_payload_o !== 32'h5) begin
            errors++; $display("FAIL np_out_5: got vld=%b data=%h expected vld=1 data=5", out_vld_o, out_payload_o);
        end
        checks++;
        if (in_rdy_o[0] !== 1'b1) begin
            errors++; $display("FAIL np_reload_rdy: got %b expected 1", in_rdy_o[0]);
        end
        tick();
        drive(2'b00, 32'h0, 32'h0);
        checks++;
        if (out_vld_o !== 1'b1 || out_payload_o !== 32'h6) begin
            errors++; $display("FAIL np_out_6: got vld=%b data=%h expected vld=1 data=6", out_vld_o, out_payload_o);
        end
        tick();
        checks++;
        if (out_vld_o !== 1'b0) begin
            errors++; $display("FAIL np_drained: got %b expected 0 (single entry only)", out_vld_o);
        end
    endtask

    task automatic test_flush();
        out_rdy_i = 1'b1;
        drive(2'b11, 32'hA, 32'hB);
        tick();
        drive(2'b00, 32'h0, 32'h0);
        checks++;
        if (out_payload_o !== 32'hA) begin
            errors++; $display("FAIL fl_out_A: got %h expected a", out_payload_o);
        end
        tick();
        checks++;
        if (out_vld_o !== 1'b1 || out_payload_o !== 32'hB) begin
            errors++; $display("FAIL fl_pending_B: got vld=%b data=%h expected vld=1 data=b", out_vld_o, out_payload_o);
        end
        flush_i = 1'b1;
        drive(2'b11, 32'hE, 32'hF);
        checks++;
        if (in_rdy_o !== 2'b00) begin
            errors++; $display("FAIL fl_rdy: got %b expected 00", in_rdy_o);
        end
        tick();
        flush_i = 1'b0;
        drive(2'b00, 32'h0, 32'h0);
        checks++;
        if (out_vld_o !== 1'b0) begin
            errors++; $display("FAIL fl_cleared: got vld=%b expected 0", out_vld_o);
        end
        tick();
        checks++;
        if (out_vld_o !== 1'b0) begin
            errors++; $display("FAIL fl_stays_empty: got vld=%b expected 0", out_vld_o);
        end
    endtask

    task automatic test_async_reset();
        out_rdy_i = 1'b0;
        drive(2'b11, 32'hA, 32'hB);
        tick();
        drive(2'b00, 32'h0, 32'h0);
        out_rdy_i = 1'b1;
        tick();
        out_rdy_i = 1'b0;
        #1;
        checks++;
        if (out_vld_o !== 1'b1 || out_payload_o !== 32'hB) begin
            errors++; $display("FAIL ar_pending_B: got vld=%b data=%h expected vld=1 data=b", out_vld_o, out_payload_o);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_vld_o !== 1'b0) begin
            errors++; $display("FAIL ar_async_drop: got vld=%b expected 0", out_vld_o);
        end
        rst = 1'b0;
        drive(2'b00, 32'h0, 32'h0);
        tick();
        checks++;
        if (out_vld_o !== 1'b0) begin
            errors++; $display("FAIL ar_empty_after: got vld=%b expected 0", out_vld_o);
        end
        drive(2'b11, 32'h0, 32'h0);
        checks++;
        if (in_rdy_o !== 2'b11) begin
            errors++; $display("FAIL ar_rdy_after: got %b expected 11", in_rdy_o);
        end
        drive(2'b00, 32'h0, 32'h0);
    endtask

    initial begin
        rst          = 1'b1;
        in_vld_i     = '0;
        in_payload_i = '0;
        out_rdy_i    = 1'b0;
        flush_i      = 1'b0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_non_prefix();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
